// File: rtl/fifo_tx_serializer_pkg.sv
// Shared types and sizing helpers for the IMT word FIFO transmit path.
package fifo_tx_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  localparam int unsigned IMT_WORD_W = 64;
  localparam int unsigned IMT_BEAT_W = 8;

  function automatic int unsigned nbeats(input int unsigned dw, input int unsigned bw);
    return dw / bw;
  endfunction

  function automatic int unsigned idx_w(input int unsigned dw, input int unsigned bw);
    return $clog2(dw / bw);
  endfunction

endpackage

// File: rtl/fifo_tx_serializer.sv
// Pops FIFO words and serializes them into BEAT_WIDTH beats on a valid/ready stream,
// with zero-bubble back-to-back words, synchronous flush and a completed-word counter.
module fifo_tx_serializer
  import fifo_tx_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IMT_WORD_W,
  parameter int unsigned BEAT_WIDTH = IMT_BEAT_W,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  beat_valid_o,
  input  logic                  beat_ready_i,
  output logic [BEAT_WIDTH-1:0] beat_data_o,
  output logic                  beat_last_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  word_cnt_o
);

  localparam int unsigned NBEATS = nbeats(DATA_WIDTH, BEAT_WIDTH);
  localparam int unsigned IdxW   = idx_w(DATA_WIDTH, BEAT_WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBEATS - 1);

  if ((NBEATS < 2) || ((DATA_WIDTH % BEAT_WIDTH) != 0)) begin : g_bad_params
    $error("fifo_tx_serializer: DATA_WIDTH must be a multiple of BEAT_WIDTH with at least 2 beats");
  end

  ser_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IdxW-1:0]       r_idx;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_send;
  logic                  w_last;
  logic                  w_hs;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  assign w_send = (r_state == SEND);
  assign w_last = w_send && (r_idx == LastIdx);
  assign w_hs   = w_send && beat_ready_i;

  // Pop is combinational so the next word loads on the same edge as the last beat;
  // gated by rst so all outputs read 0 while reset is held.
  assign w_pop = !rst && !flush_i && !fifo_empty_i && (!w_send || (w_last && beat_ready_i));

  assign w_shift_nxt = MSB_FIRST ? (r_shift << BEAT_WIDTH) : (r_shift >> BEAT_WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
    end else if (flush_i) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_pop) begin
      r_state <= SEND;
      r_shift <= fifo_data_i;
      r_idx   <= '0;
    end else if (w_hs) begin
      if (w_last) begin
        r_state <= IDLE;
      end else begin
        r_shift <= w_shift_nxt;
        r_idx   <= r_idx + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!flush_i && w_hs && w_last) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign fifo_pop_o   = w_pop;
  assign beat_valid_o = w_send;
  assign beat_last_o  = w_last;
  assign busy_o       = w_send;
  assign word_cnt_o   = r_cnt;
  assign beat_data_o  = MSB_FIRST ? r_shift[DATA_WIDTH-1 -: BEAT_WIDTH] : r_shift[BEAT_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Bench for fifo_tx_serializer: per-cycle reference model, table vectors and directed corner cases.
module tb_fifo_tx_serializer;

  localparam int DW = 64;
  localparam int BW = 8;
  localparam int NB = DW / BW;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: default parameters (LSB first, 16-bit counter)
  logic          a_flush, a_empty, a_pop, a_valid, a_ready, a_last, a_busy;
  logic [DW-1:0] a_data;
  logic [BW-1:0] a_beat;
  logic [CW-1:0] a_cnt;

  // Instance B: MSB first, 2-bit counter
  logic          b_flush, b_empty, b_pop, b_valid, b_ready, b_last, b_busy;
  logic [DW-1:0] b_data;
  logic [BW-1:0] b_beat;
  logic [1:0]    b_cnt;

  fifo_tx_serializer dut_a (
    .clk(clk), .rst(rst), .flush_i(a_flush), .fifo_empty_i(a_empty), .fifo_data_i(a_data),
    .fifo_pop_o(a_pop), .beat_valid_o(a_valid), .beat_ready_i(a_ready), .beat_data_o(a_beat),
    .beat_last_o(a_last), .busy_o(a_busy), .word_cnt_o(a_cnt)
  );

  fifo_tx_serializer #(.DATA_WIDTH(DW), .BEAT_WIDTH(BW), .MSB_FIRST(1'b1), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .flush_i(b_flush), .fifo_empty_i(b_empty), .fifo_data_i(b_data),
    .fifo_pop_o(b_pop), .beat_valid_o(b_valid), .beat_ready_i(b_ready), .beat_data_o(b_beat),
    .beat_last_o(b_last), .busy_o(b_busy), .word_cnt_o(b_cnt)
  );

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [BW-1:0] a_log[$];
  logic          a_lastlog[$];
  logic [BW-1:0] b_log[$];
  logic [1:0]    b_cnts[$];
  int            a_pops;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: word in flight and how many of its beats were already accepted
  bit            m_busy;
  int            m_k;
  logic [DW-1:0] m_word;
  int unsigned   m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] beat_lsb(input logic [DW-1:0] w, input int k);
    return BW'(w >> (k * BW));
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_k    = 0;
    m_word = '0;
    m_cnt  = 0;
  endtask

  task automatic step(input logic rdy, input logic fl);
    bit  exp_last, exp_pop, b_done;
    @(negedge clk);
    a_ready = rdy;
    a_flush = fl;
    a_empty = (qa.size() == 0);
    a_data  = a_empty ? '0 : qa[0];
    b_ready = 1'b1;
    b_flush = 1'b0;
    b_empty = (qb.size() == 0);
    b_data  = b_empty ? '0 : qb[0];
    #1;
    exp_last = m_busy && (m_k == NB - 1);
    exp_pop  = !fl && (qa.size() > 0) && (!m_busy || (rdy && exp_last));
    chk("valid", a_valid, m_busy);
    chk("busy", a_busy, m_busy);
    chk("last", a_last, exp_last);
    chk("pop", a_pop, exp_pop);
    chk("cnt", a_cnt, m_cnt[CW-1:0]);
    if (m_busy) chk("beat", a_beat, beat_lsb(m_word, m_k));

    if (a_pop) a_pops++;
    if (a_valid && rdy && !fl) begin
      a_log.push_back(a_beat);
      a_lastlog.push_back(a_last);
    end
    if (b_valid) b_log.push_back(b_beat);
    b_done = b_valid && b_last;

    if (fl) begin
      m_busy = 0;
      m_k    = 0;
    end else if (m_busy) begin
      if (rdy) begin
        if (m_k == NB - 1) begin
          m_cnt++;
          if (qa.size() > 0) begin
            m_word = qa[0];
            m_k    = 0;
          end else begin
            m_busy = 0;
          end
        end else begin
          m_k++;
        end
      end
    end else if (qa.size() > 0) begin
      m_word = qa[0];
      m_busy = 1;
      m_k    = 0;
    end

    @(posedge clk);
    if (a_pop) void'(qa.pop_front());
    if (b_pop) void'(qb.pop_front());
    #1;
    if (b_done) b_cnts.push_back(b_cnt);
  endtask

  typedef struct {
    logic [DW-1:0] word;
    logic [7:0]    rdy_pat;
    logic [BW-1:0] beats[NB];
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic [CW-1:0] cnt0;
    int            n;

    vecs[0].word = 64'h0807060504030201; vecs[0].rdy_pat = 8'hFF;
    vecs[0].beats = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    vecs[1].word = 64'hAABBCCDD11223344; vecs[1].rdy_pat = 8'b1001_1001;
    vecs[1].beats = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    vecs[2].word = 64'hFFFFFFFF00000000; vecs[2].rdy_pat = 8'b0110_1001;
    vecs[2].beats = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    rst = 1'b1;
    a_flush = 0; a_empty = 1; a_data = '0; a_ready = 0;
    b_flush = 0; b_empty = 1; b_data = '0; b_ready = 1;
    a_pops = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst valid", a_valid, 0);
    chk("rst pop", a_pop, 0);
    chk("rst cnt", a_cnt, 0);
    chk("rst beat", a_beat, 0);
    rst = 1'b0;

    // Table-driven single words with per-vector ready patterns
    for (int v = 0; v < 3; v++) begin
      cnt0 = a_cnt;
      a_log.delete(); a_lastlog.delete();
      a_pops = 0;
      qa.push_back(vecs[v].word);
      n = 0;
      while (a_log.size() < NB && n < 80) begin
        step(vecs[v].rdy_pat[n % 8], 1'b0);
        n++;
      end
      chk("vec beat count", a_log.size(), NB);
      for (int i = 0; i < a_log.size(); i++) begin
        chk("vec beat", a_log[i], vecs[v].beats[i]);
        chk("vec last", a_lastlog[i], (i == NB - 1));
      end
      chk("vec pops", a_pops, 1);
      chk("vec cnt", a_cnt, cnt0 + 1);
      chk("vec idle", a_busy, 0);
    end

    // Back-to-back: three queued words, one initial pop then 24 gapless beats
    cnt0 = a_cnt;
    a_log.delete(); a_lastlog.delete();
    a_pops = 0;
    qa.push_back(64'h1111111111111111);
    qa.push_back(64'h2222222222222222);
    qa.push_back(64'h3333333333333333);
    n = 0;
    while (a_cnt != cnt0 + 3 && n < 60) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("b2b cycles", n, 25);
    chk("b2b pops", a_pops, 3);
    chk("b2b beats", a_log.size(), 24);
    chk("b2b cnt", a_cnt, cnt0 + 3);

    // Flush after beat 3 with another word waiting
    a_log.delete(); a_lastlog.delete();
    qa.push_back(64'hAABBCCDD11223344);
    n = 0;
    while (a_log.size() < 3 && n < 20) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("flush pre beats", a_log.size(), 3);
    qa.push_back(64'h0807060504030201);
    cnt0 = a_cnt;
    a_pops = 0;
    step(1'b1, 1'b1);
    chk("flush no pop", a_pops, 0);
    chk("flush idle", a_busy, 0);
    chk("flush cnt kept", a_cnt, cnt0);
    chk("flush fifo kept", qa.size(), 1);
    a_log.delete(); a_lastlog.delete();
    n = 0;
    while (a_log.size() < NB && n < 20) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("post flush beats", a_log.size(), NB);
    for (int i = 0; i < a_log.size(); i++) chk("post flush beat", a_log[i], i + 1);
    chk("post flush cnt", a_cnt, cnt0 + 1);

    // MSB-first instance with 2-bit counter wrap
    b_log.delete(); b_cnts.delete();
    for (int i = 0; i < 5; i++) qb.push_back(64'h0102030405060708);
    n = 0;
    while (b_cnts.size() < 5 && n < 80) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("wrap words", b_cnts.size(), 5);
    chk("wrap beats", b_log.size(), 40);
    for (int i = 0; i < b_log.size(); i++) chk("wrap beat", b_log[i], (i % NB) + 1);
    for (int i = 0; i < b_cnts.size(); i++) chk("wrap cnt", b_cnts[i], (i + 1) % 4);

    // Asynchronous reset in the middle of a word
    qa.push_back(64'h0807060504030201);
    repeat (3) step(1'b1, 1'b0);
    chk("pre rst busy", a_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst valid", a_valid, 0);
    chk("async rst busy", a_busy, 0);
    chk("async rst last", a_last, 0);
    chk("async rst beat", a_beat, 0);
    chk("async rst cnt", a_cnt, 0);
    chk("async rst pop", a_pop, 0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    a_pops = 0;
    repeat (10) step(1'b1, 1'b0);
    chk("post rst pops", a_pops, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0 && qa.size() < 4) qa.push_back({$urandom, $urandom});
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_tx_serializer.md
Name: fifo_tx_serializer

Overview:
Downstream consumer of the IMT word FIFO. Pops DATA_WIDTH-bit words from the FIFO read port and emits them as BEAT_WIDTH-bit beats on a valid/ready stream toward the narrow off-chip or bus-side link. It supports zero-bubble back-to-back words, a synchronous flush, and a running count of completed words.

Parameters:
DATA_WIDTH, 64, width of a FIFO word
BEAT_WIDTH, 8, width of one output beat; DATA_WIDTH % BEAT_WIDTH == 0 required
MSB_FIRST, 0, 0: beat 0 is bits [BEAT_WIDTH-1:0]; 1: beat 0 is the top BEAT_WIDTH bits
CNT_WIDTH, 16, width of the completed-word counter

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
flush_i  input  1  synchronous flush; abandons the current word
fifo_empty_i  input  1  FIFO empty flag
fifo_data_i  input  DATA_WIDTH  FIFO head word; valid combinationally whenever !fifo_empty_i
fifo_pop_o  output  1  pop strobe to the FIFO; head is consumed at the same clock edge
beat_valid_o  output  1  beat available
beat_ready_i  input  1  sink accepts the beat
beat_data_o  output  BEAT_WIDTH  current beat
beat_last_o  output  1  current beat is the final beat of its word
busy_o  output  1  a word is loaded (state SEND)
word_cnt_o  output  CNT_WIDTH  number of fully transmitted words, wraps modulo 2^CNT_WIDTH

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- NBEATS = DATA_WIDTH/BEAT_WIDTH. Must be >= 2; elaboration fails otherwise.
- Beat index: IdxW = $clog2(NBEATS) bits.
- Reset values: state=IDLE, shift register=0, beat index=0, word_cnt_o=0. All outputs are 0 during and after reset.
- FSM has 2 states: IDLE, SEND.
- IDLE:
  - fifo_pop_o = !fifo_empty_i && !flush_i (combinational).
  - On pop: shift_q <= fifo_data_i, idx <= 0, go to SEND.
  - Latency: a word visible at edge t gives first beat valid at t+1.
- SEND:
  - beat_valid_o=1. beat_data_o = low (or high, if MSB_FIRST) BEAT_WIDTH bits of shift_q. beat_last_o = (idx == NBEATS-1).
  - valid && !ready: hold everything. beat_data_o and beat_last_o must stay stable; valid must not drop.
  - Handshake on a non-last beat: shift shift_q by BEAT_WIDTH toward the output end, zero fill, idx++.
  - Handshake on the last beat: word_cnt_o++.
    - If !fifo_empty_i: fifo_pop_o=1 in that same cycle, load the new word, idx <= 0, stay in SEND (zero bubble).
    - Otherwise go to IDLE.
- fifo_pop_o is never asserted in SEND except on the last-beat handshake. It is never asserted when fifo_empty_i=1.
- flush_i (either state):
  - Next state IDLE, idx <= 0, shift_q <= 0.
  - No pop that cycle, and word_cnt_o is not incremented even if the last beat handshakes.
  - word_cnt_o itself is retained.
  - beat_valid_o may still be 1 in the flush cycle; the sink must ignore it.
- Reset mid-word: the word is lost. Outputs drop to 0 asynchronously.
- word_cnt_o wraps to 0 after 2^CNT_WIDTH-1 with no sticky flag.
- busy_o = (state == SEND).

Decomposition:
- Shared package imt_pkg:
  - ser_state_e enum {IDLE, SEND}.
  - Localparam helpers for NBEATS and IdxW.
  - Default widths IMT_WORD_W=64 and IMT_BEAT_W=8, shared with the FIFO instance.
- Flops use the codebase register macros with the flush variant, adapted for active-high async reset.
- No sub-module. An optional top wrapper imt_tx_path instantiates the FIFO plus this block; it is not part of this block.

Test Plan:
- Reset: assert rst mid-simulation -> all outputs 0 asynchronously; after release with fifo_empty_i=1, no pop and no valid for 10 cycles.
- Single word, ready always 1: 0x0807060504030201 with MSB_FIRST=0 -> one pop, then 8 consecutive beats 0x01..0x08, beat_last_o only on 0x08, word_cnt_o=1, return to IDLE.
- Back-to-back: FIFO holds 3 words -> 24 beats with no idle cycle between words; pop asserted exactly on beats 8 and 16 (plus the initial IDLE pop); word_cnt_o=3.
- Backpressure: beat_ready_i toggles 1,0,0,1 pseudo-randomly -> beat_data_o stable while stalled; beat order 0x01..0x08 intact; no extra pop.
- Flush: assert flush_i after beat 3 of word 0xAABBCCDD11223344 -> next cycle IDLE, word_cnt_o unchanged, no pop in the flush cycle; a subsequent word is serialized from beat 0.
- Counter wrap and MSB_FIRST=1, CNT_WIDTH=2: send 5 words of 0x0102030405060708 -> beats emitted 0x01..0x08 in order; word_cnt_o reads 1,2,3,0,1.
